// File: rtl/rk4_step_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rk4_step_sequencer_if
// Purpose  : Handshake bundle between the RK4 step sequencer and the
//            arithmetic datapath (stage start/select/done, state commit).
// Revision : 1.0  initial release
// ============================================================================
interface rk4_step_sequencer_if;
   logic       stage_start;
   logic [1:0] stage_sel;
   logic       stage_done;
   logic       state_update;

   // Sequencer side drives the stage control and commit strobe
   modport master (
      output stage_start,
      output stage_sel,
      output state_update,
      input  stage_done
   );

   // Datapath side answers with stage_done
   modport slave (
      input  stage_start,
      input  stage_sel,
      input  state_update,
      output stage_done
   );
endinterface
`default_nettype wire

// File: rtl/rk4_step_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rk4_step_sequencer
// Purpose  : Runs one RK4 integration step per rising edge of the divided
//            step clock: sequences k1..k4 through the datapath handshake,
//            pulses the state commit, flags overruns and datapath hangs.
// Revision : 1.0  initial release
// ============================================================================
module rk4_step_sequencer #(
   parameter int STEP_W         = 16,
   parameter int TIMEOUT_CYCLES = 40,
   parameter int TO_W           = 6
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  tick_clk,
   input  logic                  clear_err,
   rk4_step_sequencer_if.master  dp,
   output logic                  busy,
   output logic [STEP_W-1:0]     step_count,
   output logic                  overrun,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   // Counter value during the last permitted WAIT cycle of a stage
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic                r_tick_q1;
   logic                r_tick_q2;
   logic                r_tick_q3;
   logic                w_tick_rise;
   logic [1:0]          r_stage_sel;
   logic [TO_W-1:0]     r_to_cnt;
   logic [STEP_W-1:0]   r_step_count;
   logic                r_overrun;
   logic                r_timeout_err;
   logic                w_start_step;
   logic                w_stage_adv;
   logic                w_abort;

   // Synchronise the divided clock and keep one extra stage for edge detect
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_tick_q1 <= 1'b0;
         r_tick_q2 <= 1'b0;
         r_tick_q3 <= 1'b0;
      end else begin
         r_tick_q1 <= tick_clk;
         r_tick_q2 <= r_tick_q1;
         r_tick_q3 <= r_tick_q2;
      end
   end

   assign w_tick_rise = r_tick_q2 & ~r_tick_q3;

   // FSM state register
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; stage_done outside WAIT is ignored, done beats expiry
   always_comb begin
      w_next_state = r_state;
      w_start_step = 1'b0;
      w_stage_adv  = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_tick_rise && enable) begin
               w_next_state = ST_ISSUE;
               w_start_step = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (dp.stage_done) begin
               if (r_stage_sel == 2'd3) begin
                  w_next_state = ST_COMMIT;
               end else begin
                  w_next_state = ST_ISSUE;
                  w_stage_adv  = 1'b1;
               end
            end else if (r_to_cnt == c_to_last) begin
               w_next_state = ST_IDLE;
               w_abort      = 1'b1;
            end
         end
         ST_COMMIT: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Stage index, per-stage timeout counter, step counter and sticky flags
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_stage_sel   <= 2'd0;
         r_to_cnt      <= '0;
         r_step_count  <= '0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_start_step || w_abort) begin
            r_stage_sel <= 2'd0;
         end else if (w_stage_adv) begin
            r_stage_sel <= r_stage_sel + 2'd1;
         end

         if (r_state == ST_ISSUE) begin
            r_to_cnt <= '0;
         end else if ((r_state == ST_WAIT) && !dp.stage_done) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (r_state == ST_COMMIT) begin
            r_step_count <= r_step_count + STEP_W'(1);
         end

         // A set event in the same cycle as clear_err takes priority
         if (w_tick_rise && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end else if (clear_err) begin
            r_overrun <= 1'b0;
         end

         if (w_abort) begin
            r_timeout_err <= 1'b1;
         end else if (clear_err) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign dp.stage_start  = (r_state == ST_ISSUE);
   assign dp.state_update = (r_state == ST_COMMIT);
   assign dp.stage_sel    = r_stage_sel;
   assign busy            = (r_state != ST_IDLE);
   assign step_count      = r_step_count;
   assign overrun         = r_overrun;
   assign timeout_err     = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rk4_step_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rk4_step_sequencer
// Purpose  : Directed, self-checking bench for rk4_step_sequencer: a vector
//            table for the nominal step plus hand-written corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_rk4_step_sequencer;

   localparam int STEP_W = 16;

   typedef struct packed {
      logic        tick;
      logic        start;
      logic [1:0]  sel;
      logic        upd;
      logic        bsy;
      logic [15:0] cnt;
   } vec_t;

   logic              clk_in = 1'b0;
   logic              reset;
   logic              enable;
   logic              enable_w;
   logic              tick_clk;
   logic              clear_err;
   logic              busy;
   logic [STEP_W-1:0] step_count;
   logic              overrun;
   logic              timeout_err;
   logic              busy_w;
   logic [2:0]        step_count_w;
   logic              overrun_w;
   logic              timeout_err_w;

   int                n_pass  = 0;
   int                n_total = 0;
   int                dly [4];
   int                rsp_cnt = 0;
   int                n_updates = 0;
   logic [1:0]        start_log [$];
   vec_t              vtab [12];

   rk4_step_sequencer_if bus ();
   rk4_step_sequencer_if bus_w ();

   always #5 clk_in = ~clk_in;

   rk4_step_sequencer #(.STEP_W(STEP_W), .TIMEOUT_CYCLES(40), .TO_W(6)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable),
      .tick_clk    (tick_clk),
      .clear_err   (clear_err),
      .dp          (bus),
      .busy        (busy),
      .step_count  (step_count),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   // Narrow counter instance so counter wrap is reachable in a short run
   rk4_step_sequencer #(.STEP_W(3), .TIMEOUT_CYCLES(40), .TO_W(6)) dut_w (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable_w),
      .tick_clk    (tick_clk),
      .clear_err   (clear_err),
      .dp          (bus_w),
      .busy        (busy_w),
      .step_count  (step_count_w),
      .overrun     (overrun_w),
      .timeout_err (timeout_err_w)
   );

   // Datapath model: done on the dly[sel]-th WAIT cycle, 0 = never answer
   always @(posedge clk_in) begin
      #1;
      bus.stage_done = 1'b0;
      if (!reset) begin
         rsp_cnt = 0;
      end else begin
         if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) bus.stage_done = 1'b1;
         end
         if (bus.stage_start) rsp_cnt = dly[bus.stage_sel];
      end
   end

   // Narrow instance always answers in the first WAIT cycle
   always @(posedge clk_in) bus_w.stage_done <= bus_w.stage_start;

   // Monitor on the falling edge, away from the active edge
   always @(negedge clk_in) begin
      if (bus.stage_start) start_log.push_back(bus.stage_sel);
      if (bus.state_update) n_updates = n_updates + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick_pulse();
      tick_clk = 1'b1;
      repeat (3) cyc();
      tick_clk = 1'b0;
      cyc();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         cyc();
      end
      if (busy) check("wait_idle_bound", 32'(busy), 32'd0);
   endtask

   task automatic check_seq(input string name);
      logic [7:0] seq;
      seq = '0;
      for (int i = 0; i < start_log.size() && i < 4; i++) seq[7-2*i -: 2] = start_log[i];
      check({name, "_starts"}, 32'(start_log.size()), 32'd4);
      check({name, "_sel_order"}, 32'(seq), 32'h1B);
   endtask

   initial begin
      int k_at;
      int upd0;

      // tick, start, sel, upd, busy, step_count ; row k applies tick before edge k
      vtab[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
      vtab[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
      vtab[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 16'd0};
      vtab[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd0};
      vtab[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 16'd0};
      vtab[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 16'd0};
      vtab[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 16'd0};
      vtab[7]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'd0};
      vtab[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 16'd0};
      vtab[9]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 16'd0};
      vtab[10] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 16'd0};
      vtab[11] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd1};

      reset     = 1'b0;
      enable    = 1'b1;
      enable_w  = 1'b0;
      tick_clk  = 1'b0;
      clear_err = 1'b0;
      dly       = '{1, 1, 1, 1};
      repeat (3) cyc();

      // Reset state
      check("reset_outputs",
            32'({bus.stage_start, bus.stage_sel, bus.state_update, busy, overrun, timeout_err}), 32'd0);
      check("reset_count", 32'(step_count), 32'd0);
      reset = 1'b1;
      repeat (3) cyc();

      // Reset asserted while waiting on k3
      dly = '{1, 1, 0, 1};
      tick_pulse();
      k_at = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy && !bus.stage_start && bus.stage_sel == 2'd2) break;
         cyc();
         k_at++;
      end
      check("midwait_reached_sel", 32'(bus.stage_sel), 32'd2);
      reset = 1'b0;
      #2;
      check("midwait_reset_outputs",
            32'({bus.stage_start, bus.stage_sel, bus.state_update, busy, overrun, timeout_err}), 32'd0);
      check("midwait_reset_count", 32'(step_count), 32'd0);
      repeat (2) cyc();
      reset = 1'b1;
      upd0 = n_updates;
      repeat (15) cyc();
      check("midwait_no_commit", 32'(n_updates - upd0), 32'd0);
      check("midwait_idle", 32'(busy), 32'd0);

      // Nominal step, table driven
      dly = '{1, 1, 1, 1};
      for (int k = 0; k < 12; k++) begin
         tick_clk = vtab[k].tick;
         cyc();
         check($sformatf("nominal_row%0d", k),
               32'({bus.stage_start, bus.stage_sel, bus.state_update, busy, step_count}),
               32'({vtab[k].start, vtab[k].sel, vtab[k].upd, vtab[k].bsy, vtab[k].cnt}));
      end
      tick_clk = 1'b0;
      repeat (4) cyc();

      // Datapath never answers k2: abort exactly after the 40th WAIT cycle
      dly = '{1, 0, 1, 1};
      tick_pulse();
      for (int i = 0; i < 10; i++) begin
         if (bus.stage_start && bus.stage_sel == 2'd1) break;
         cyc();
      end
      check("to_k2_issued", 32'({bus.stage_start, bus.stage_sel}), 32'h5);
      repeat (40) cyc();
      check("to_still_waiting", 32'({busy, timeout_err}), 32'h2);
      cyc();
      check("to_flag_set", 32'({busy, timeout_err}), 32'h1);
      check("to_sel_reset", 32'(bus.stage_sel), 32'd0);
      check("to_count_kept", 32'(step_count), 32'd1);
      dly = '{1, 1, 1, 1};
      start_log.delete();
      tick_pulse();
      wait_idle(40);
      check_seq("to_restart");
      check("to_restart_count", 32'(step_count), 32'd2);
      check("to_sticky", 32'(timeout_err), 32'd1);
      clear_err = 1'b1;
      cyc();
      clear_err = 1'b0;
      check("to_cleared", 32'(timeout_err), 32'd0);

      // Done on the 40th WAIT cycle is accepted
      dly = '{1, 40, 1, 1};
      upd0 = n_updates;
      tick_pulse();
      wait_idle(100);
      check("late_done_no_err", 32'(timeout_err), 32'd0);
      check("late_done_count", 32'(step_count), 32'd3);
      check("late_done_one_commit", 32'(n_updates - upd0), 32'd1);

      // Second tick while busy, enable dropped mid-step
      dly = '{1, 1, 1, 1};
      upd0 = n_updates;
      start_log.delete();
      tick_pulse();
      tick_pulse();
      enable = 1'b0;
      wait_idle(40);
      repeat (15) cyc();
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_one_commit", 32'(n_updates - upd0), 32'd1);
      check_seq("ovr");
      check("ovr_count", 32'(step_count), 32'd4);
      clear_err = 1'b1;
      cyc();
      clear_err = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);
      start_log.delete();
      tick_pulse();
      repeat (10) cyc();
      check("disabled_no_start", 32'(start_log.size()), 32'd0);
      check("disabled_no_overrun", 32'(overrun), 32'd0);

      // Counter wrap on the narrow instance
      enable_w = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         tick_pulse();
         repeat (12) cyc();
         if (s == 7) check("wrap_count_max", 32'(step_count_w), 32'd7);
      end
      check("wrap_count_zero", 32'(step_count_w), 32'd0);
      check("wrap_flags", 32'({busy_w, overrun_w, timeout_err_w}), 32'd0);
      check("wrap_main_ignored", 32'(step_count), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
